// File: rtl/circ_matvec_pkg.sv
`default_nettype none
// circ_matvec_pkg: handshake state type, default generator row and the
// N-bit rotate-left helper shared by the req/res responders.
package circ_matvec_pkg;

  typedef enum logic [1:0] {
    HS_IDLE = 2'd0,
    HS_BUSY = 2'd1,
    HS_DONE = 2'd2
  } hs_state_e;

  // Widest row the rotate helper handles; callers zero-extend into it.
  localparam int ROT_MAXW = 512;

  localparam logic [127:0] DEFAULT_C = 128'h8000_0000_0000_0000_0000_0000_0000_0001;

  // rotl(v,s,n)[b] = v[(b-s) mod n] over the low n bits; bits >= n come back zero.
  function automatic logic [ROT_MAXW-1:0] rotl(
    input logic [ROT_MAXW-1:0] v,
    input int                  s,
    input int                  n
  );
    logic [ROT_MAXW-1:0] mask;
    int                  sh;
    sh   = s % n;
    mask = {ROT_MAXW{1'b1}} >> (ROT_MAXW - n);
    return ((v << sh) | (v >> (n - sh))) & mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/circ_matvec_gf2_dot.sv
`default_nettype none
// gf2_dot: GF(2) inner product of two N-bit vectors (AND then XOR-reduce).
module gf2_dot #(
  parameter int N = 128
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         y
);

  assign y = ^(a & b);

endmodule
`default_nettype wire

// File: rtl/circ_matvec.sv
`default_nettype none
// circ_matvec: y = A*x over GF(2) with A an MxN circulant built from row C,
// evaluated P rows per cycle behind the req/res responder handshake.
module circ_matvec
  import circ_matvec_pkg::*;
#(
  parameter int            M = 256,
  parameter int            N = 128,
  parameter int            P = 1,
  parameter logic [N-1:0]  C = N'(DEFAULT_C)
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] x_in,
  output logic [M-1:0] y_out,
  input  logic         req_valid,
  output logic         req_ready,
  output logic         req_busy,
  output logic         res_valid,
  input  logic         res_ready
);

  localparam int            KW     = $clog2(M) + 1;
  localparam int            NG     = M / P;
  localparam logic [KW-1:0] K_LAST = KW'(M - P);
  localparam logic [KW-1:0] K_STEP = KW'(P);

  if (M % P != 0) begin : g_bad_p
    $error("circ_matvec: M must be a multiple of P");
  end
  if (N > ROT_MAXW) begin : g_bad_n
    $error("circ_matvec: N exceeds rotate helper width");
  end

  hs_state_e     state;
  logic [N-1:0]  x_r;
  logic [N-1:0]  rot_r;
  logic [N-1:0]  rot_next;
  logic [KW-1:0] k;
  logic [P-1:0]  row_bits;

  // Row k+j of A is the current row rotated by a further j positions.
  for (genvar j = 0; j < P; j++) begin : g_rows
    logic [N-1:0] row_j;
    assign row_j = N'(rotl(ROT_MAXW'(rot_r), j, N));
    gf2_dot #(
      .N (N)
    ) u_dot (
      .a (x_r),
      .b (row_j),
      .y (row_bits[j])
    );
  end

  assign rot_next = N'(rotl(ROT_MAXW'(rot_r), P % N, N));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= HS_IDLE;
      x_r   <= '0;
      rot_r <= C;
      k     <= '0;
    end else begin
      case (state)
        HS_IDLE: begin
          if (req_valid) begin
            x_r   <= x_in;
            rot_r <= C;
            k     <= '0;
            state <= HS_BUSY;
          end
        end
        HS_BUSY: begin
          rot_r <= rot_next;
          k     <= k + K_STEP;
          if (k == K_LAST) begin
            state <= HS_DONE;
          end
        end
        HS_DONE: begin
          if (res_ready) begin
            state <= HS_IDLE;
          end
        end
        default: state <= HS_IDLE;
      endcase
    end
  end

  // Each row group owns a fixed slice of y_out, enabled when k points at it.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      y_out <= '0;
    end else if (state == HS_BUSY) begin
      for (int g = 0; g < NG; g++) begin
        if (k == KW'(g * P)) begin
          y_out[g*P +: P] <= row_bits;
        end
      end
    end
  end

  assign req_ready = (state == HS_IDLE);
  assign req_busy  = (state == HS_BUSY);
  assign res_valid = (state == HS_DONE);

endmodule
`default_nettype wire

// File: tb/tb_circ_matvec.sv
`default_nettype none
// tb_circ_matvec: directed checks on small (8x4, P=1/2) and default-size
// instances against a direct-formula GF(2) matrix-vector model.
module tb_circ_matvec;

  localparam logic [127:0] CD = 128'h8000_0000_0000_0000_0000_0000_0000_0001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rstn_a, rv_a, rr_a, rdy_a, bsy_a, val_a;
  logic [3:0]   x_a;
  logic [7:0]   y_a;
  logic         rstn_b, rv_b, rr_b, rdy_b, bsy_b, val_b;
  logic [3:0]   x_b;
  logic [7:0]   y_b;
  logic         rstn_d, rv_d, rr_d, rdy_d, bsy_d, val_d;
  logic [127:0] x_d;
  logic [255:0] y_d;

  circ_matvec #(.M(8), .N(4), .P(1), .C(4'b0011)) dut_a (
    .clk(clk), .rstn(rstn_a), .x_in(x_a), .y_out(y_a), .req_valid(rv_a),
    .req_ready(rdy_a), .req_busy(bsy_a), .res_valid(val_a), .res_ready(rr_a));

  circ_matvec #(.M(8), .N(4), .P(2), .C(4'b0011)) dut_b (
    .clk(clk), .rstn(rstn_b), .x_in(x_b), .y_out(y_b), .req_valid(rv_b),
    .req_ready(rdy_b), .req_busy(bsy_b), .res_valid(val_b), .res_ready(rr_b));

  circ_matvec dut_d (
    .clk(clk), .rstn(rstn_d), .x_in(x_d), .y_out(y_d), .req_valid(rv_d),
    .req_ready(rdy_d), .req_busy(bsy_d), .res_valid(val_d), .res_ready(rr_d));

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // y[i] = XOR_b x[b] & A[i][b], with A[i][b] = C[(b - i) mod n].
  function automatic logic [255:0] ref_y(input int m, input int n,
                                         input logic [127:0] c, input logic [127:0] x);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < m; i++)
      for (int b = 0; b < n; b++)
        if (x[b] && c[(b - (i % n) + n) % n]) r[i] = ~r[i];
    return r;
  endfunction

  // ---------------- behavioural model + compare process ----------------
  typedef enum int {PH_IDLE, PH_BUSY, PH_DONE} ph_e;
  int           mM [3] = '{8, 8, 256};
  int           mN [3] = '{4, 4, 128};
  int           mP [3] = '{1, 2, 1};
  logic [127:0] mC [3] = '{128'h3, 128'h3, CD};
  ph_e          ph [3] = '{PH_IDLE, PH_IDLE, PH_IDLE};
  int           cnt[3] = '{0, 0, 0};
  logic [127:0] xj [3];
  logic [255:0] yl [3] = '{256'h0, 256'h0, 256'h0};

  logic         o_rdy, o_bsy, o_val, i_rst, i_rv, i_rr;
  logic [255:0] o_y;
  logic [127:0] i_x;

  task automatic observe(input int d);
    case (d)
      0: begin o_rdy = rdy_a; o_bsy = bsy_a; o_val = val_a; o_y = {248'h0, y_a};
               i_rst = rstn_a; i_rv = rv_a; i_rr = rr_a; i_x = {124'h0, x_a}; end
      1: begin o_rdy = rdy_b; o_bsy = bsy_b; o_val = val_b; o_y = {248'h0, y_b};
               i_rst = rstn_b; i_rv = rv_b; i_rr = rr_b; i_x = {124'h0, x_b}; end
      default: begin o_rdy = rdy_d; o_bsy = bsy_d; o_val = val_d; o_y = y_d;
               i_rst = rstn_d; i_rv = rv_d; i_rr = rr_d; i_x = x_d; end
    endcase
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      observe(d);
      if (mon_en) begin
        chk($sformatf("mon%0d_hs", d), {253'h0, o_rdy, o_bsy, o_val},
            {253'h0, ph[d] == PH_IDLE, ph[d] == PH_BUSY, ph[d] == PH_DONE});
        if (ph[d] != PH_BUSY) chk($sformatf("mon%0d_y", d), o_y, yl[d]);
      end
      if (!i_rst) begin
        ph[d] = PH_IDLE; yl[d] = '0; cnt[d] = 0;
      end else begin
        case (ph[d])
          PH_IDLE: if (i_rv) begin ph[d] = PH_BUSY; xj[d] = i_x; cnt[d] = 0; end
          PH_BUSY: begin
            cnt[d]++;
            if (cnt[d] == mM[d] / mP[d]) begin
              ph[d] = PH_DONE;
              yl[d] = ref_y(mM[d], mN[d], mC[d], xj[d]);
            end
          end
          default: if (i_rr) ph[d] = PH_IDLE;
        endcase
      end
    end
  end

  // ---------------- directed driver ----------------
  function automatic logic get_val(input int d);
    case (d)
      0:       return val_a;
      1:       return val_b;
      default: return val_d;
    endcase
  endfunction

  task automatic set_rv(input int d, input logic v);
    case (d) 0: rv_a = v; 1: rv_b = v; default: rv_d = v; endcase
  endtask

  task automatic set_rr(input int d, input logic v);
    case (d) 0: rr_a = v; 1: rr_b = v; default: rr_d = v; endcase
  endtask

  task automatic pulse(input int d, input logic [127:0] x);
    case (d) 0: x_a = x[3:0]; 1: x_b = x[3:0]; default: x_d = x; endcase
    set_rv(d, 1'b1);
    @(posedge clk); #2;
    set_rv(d, 1'b0);
  endtask

  task automatic wait_valid(input int d, output int cyc);
    cyc = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #2;
      cyc++;
      if (get_val(d)) break;
    end
    if (!get_val(d)) chk($sformatf("timeout%0d", d), {255'h0, get_val(d)}, 256'h1);
  endtask

  task automatic handoff(input int d);
    set_rr(d, 1'b1);
    @(posedge clk); #2;
    set_rr(d, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int           cyc;
    logic [127:0] xr;
    rstn_a = 0; rstn_b = 0; rstn_d = 0;
    rv_a = 0; rv_b = 0; rv_d = 0; rr_a = 0; rr_b = 0; rr_d = 0;
    x_a = '0; x_b = '0; x_d = '0;
    @(posedge clk); #1 mon_en = 1'b1;
    @(posedge clk); #2;
    rstn_a = 1; rstn_b = 1; rstn_d = 1;

    // reset / idle state
    chk("t1_ready", {255'h0, rdy_a}, 256'h1);
    chk("t1_busy",  {255'h0, bsy_a}, 256'h0);
    chk("t1_valid", {255'h0, val_a}, 256'h0);
    chk("t1_y",     {248'h0, y_a},   256'h0);
    chk("t1_ready_d", {255'h0, rdy_d}, 256'h1);

    // x=0001: 8 compute cycles, y=99, held while res_ready=0
    pulse(0, 128'h1);
    chk("t2_busy",  {255'h0, bsy_a}, 256'h1);
    chk("t2_nrdy",  {255'h0, rdy_a}, 256'h0);
    wait_valid(0, cyc);
    chk("t2_lat", cyc, 8);
    chk("t2_y", {248'h0, y_a}, 256'h99);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      chk("t2_hold_valid", {255'h0, val_a}, 256'h1);
      chk("t2_hold_y", {248'h0, y_a}, 256'h99);
    end
    handoff(0);
    chk("t2_ready", {255'h0, rdy_a}, 256'h1);
    chk("t2_keep_y", {248'h0, y_a}, 256'h99);

    // x=1111 -> 00, then back-to-back x=0101 with req_valid held -> FF
    pulse(0, 128'hF);
    wait_valid(0, cyc);
    chk("t3_y0", {248'h0, y_a}, 256'h00);
    x_a = 4'b0101; rv_a = 1; rr_a = 1;
    @(posedge clk); #2;
    chk("t3_idle", {255'h0, rdy_a}, 256'h1);
    rr_a = 0;
    @(posedge clk); #2;
    chk("t3_acc", {255'h0, bsy_a}, 256'h1);
    x_a = 4'hF;
    repeat (3) begin @(posedge clk); #2; end
    rv_a = 0;
    wait_valid(0, cyc);
    chk("t3_lat", cyc, 5);
    chk("t3_y1", {248'h0, y_a}, 256'hFF);
    handoff(0);

    // inputs wiggled during BUSY are ignored
    pulse(0, 128'h1);
    for (int i = 0; i < 5; i++) begin
      x_a = 4'($urandom); rr_a = ~rr_a; rv_a = ~rv_a;
      @(posedge clk); #2;
      chk("t4_busy", {255'h0, bsy_a}, 256'h1);
    end
    rv_a = 0; rr_a = 0;
    wait_valid(0, cyc);
    chk("t4_lat", cyc, 3);
    chk("t4_y", {248'h0, y_a}, 256'h99);
    handoff(0);

    // P=2: same result in 4 compute cycles
    pulse(1, 128'h1);
    wait_valid(1, cyc);
    chk("t5_lat", cyc, 4);
    chk("t5_y", {248'h0, y_b}, 256'h99);
    handoff(1);

    // reset at compute edge 3, then a fresh job
    pulse(0, 128'h1);
    @(posedge clk); #2;
    @(posedge clk); #2;
    rstn_a = 0;
    @(posedge clk); #2;
    chk("t6_ready", {255'h0, rdy_a}, 256'h1);
    chk("t6_busy",  {255'h0, bsy_a}, 256'h0);
    chk("t6_y",     {248'h0, y_a},   256'h0);
    rstn_a = 1;
    pulse(0, 128'h5);
    wait_valid(0, cyc);
    chk("t6_lat", cyc, 8);
    chk("t6_y2", {248'h0, y_a}, 256'hFF);
    handoff(0);

    // default size, random x
    for (int j = 0; j < 4; j++) begin
      xr = {$urandom, $urandom, $urandom, $urandom};
      pulse(2, xr);
      wait_valid(2, cyc);
      chk("td_lat", cyc, 256);
      chk("td_y", y_d, ref_y(256, 128, CD, xr));
      handoff(2);
    end

    // pin the model with hand-computed rows 0011,0110,1100,1001
    chk("model_x1", ref_y(8, 4, 128'h3, 128'h1), 256'h99);
    chk("model_xf", ref_y(8, 4, 128'h3, 128'hF), 256'h00);
    chk("model_x5", ref_y(8, 4, 128'h3, 128'h5), 256'hFF);
    chk("model_d1", ref_y(256, 128, CD, 128'h1),
        {128'h0000_0000_0000_0000_0000_0000_0000_0003, 128'h0000_0000_0000_0000_0000_0000_0000_0003} << 0
        & 256'h0 | {2{128'h0000_0000_0000_0000_0000_0000_0000_0003}});

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
